// File: rtl/ising_ctrl_pkg.sv
// ising_ctrl_pkg: shared constants, enums and status layout for the Ising command sequencer
package ising_ctrl_pkg;
   localparam int N      = 8;
   localparam int ADDR_W = 11;
   localparam int DATA_W = 32;
   localparam int ITER_W = 16;
   localparam int WORD_W = $clog2(N);
   localparam logic [3:0] REG_WEIGHT = 4'd0;
   localparam logic [3:0] REG_NOISE  = 4'd1;
   localparam logic [3:0] REG_THRESH = 4'd2;
   localparam logic [3:0] REG_ADDR   = 4'd3;
   localparam logic [3:0] REG_START  = 4'd5;
   localparam logic [3:0] REG_CLEAR  = 4'd15;
   typedef enum logic [1:0] {SEL_WEIGHT = 2'd0, SEL_NOISE = 2'd1, SEL_THRESH = 2'd2} mem_sel_e;
   typedef enum logic [2:0] {S_IDLE = 3'd0, S_START = 3'd1, S_WAIT = 3'd2, S_DONE = 3'd3} state_e;
   localparam int ST_BUSY  = 31;
   localparam int ST_ERR   = 30;
   localparam int ST_OVF   = 29;
   localparam int ST_STATE = 26;
   localparam int ST_WCNT  = 23;
endpackage

// File: rtl/ising_row_writer.sv
// ising_row_writer: row base/word counter and registered memory-write port
module ising_row_writer
   import ising_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              wr,
   input  mem_sel_e          sel,
   input  logic [DATA_W-1:0] data,
   input  logic              set_base,
   input  logic              clr,
   output logic              mem_we,
   output logic [1:0]        mem_sel,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [WORD_W-1:0] mem_word,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [WORD_W-1:0] word_cnt,
   output logic              ovf
);
   logic [ADDR_W-1:0] base;
   logic              wrap;
   assign wrap = word_cnt == WORD_W'(N - 1);
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_we    <= 1'b0;
         mem_sel   <= '0;
         mem_addr  <= '0;
         mem_word  <= '0;
         mem_wdata <= '0;
         word_cnt  <= '0;
         base      <= '0;
         ovf       <= 1'b0;
      end else begin
         mem_we <= wr;
         if (wr) begin
            mem_sel   <= sel;
            mem_addr  <= base;
            mem_word  <= word_cnt;
            mem_wdata <= data;
         end
         if (set_base) base <= data[ADDR_W-1:0];
         if (clr || set_base) word_cnt <= '0;
         else if (wr) word_cnt <= wrap ? '0 : word_cnt + 1'b1;
         if (clr) ovf <= 1'b0;
         else if (wr && wrap) ovf <= 1'b1;
      end
   end
endmodule

// File: rtl/ising_seq_ctrl.sv
// ising_seq_ctrl: register decode and run FSM driving the 8x8 Ising core
module ising_seq_ctrl
   import ising_ctrl_pkg::*;
(
   input  logic              aclk,
   input  logic              areset,
   input  logic              reg_wr_en,
   input  logic [3:0]        reg_wr_idx,
   input  logic [DATA_W-1:0] reg_wr_data,
   output logic              mem_we,
   output logic [1:0]        mem_sel,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [WORD_W-1:0] mem_word,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              core_clear,
   output logic              core_start,
   input  logic              core_done,
   output logic              done_irq,
   output logic [DATA_W-1:0] status
);
   state_e            state, state_nx;
   logic [ITER_W-1:0] iter_rem;
   logic [WORD_W-1:0] word_cnt;
   logic              err, ovf, idle, is_data, is_cmd, clr_hit, wr, set_base, go, drop, done_hit;
   always_comb begin
      idle     = state == S_IDLE;
      is_data  = reg_wr_idx <= REG_THRESH;
      is_cmd   = is_data || reg_wr_idx == REG_ADDR || reg_wr_idx == REG_START;
      clr_hit  = reg_wr_en && reg_wr_idx == REG_CLEAR;
      wr       = reg_wr_en && idle && is_data;
      set_base = reg_wr_en && idle && reg_wr_idx == REG_ADDR;
      go       = reg_wr_en && idle && reg_wr_idx == REG_START;
      drop     = reg_wr_en && !idle && is_cmd;
      done_hit = state == S_WAIT && core_done && !clr_hit;
      state_nx = clr_hit ? S_IDLE :
                 state == S_IDLE  ? (go ? S_START : S_IDLE) :
                 state == S_START ? S_WAIT :
                 state == S_WAIT  ? (core_done ? (iter_rem == ITER_W'(1) ? S_DONE : S_START) : S_WAIT) :
                 S_IDLE;
   end
   always_ff @(posedge aclk) begin
      if (areset) begin
         state      <= S_IDLE;
         iter_rem   <= '0;
         err        <= 1'b0;
         core_clear <= 1'b0;
      end else begin
         state      <= state_nx;
         core_clear <= clr_hit;
         err        <= clr_hit ? 1'b0 : drop ? 1'b1 : err;
         if (go) iter_rem <= reg_wr_data[ITER_W-1:0] == '0 ? ITER_W'(1) : reg_wr_data[ITER_W-1:0];
         else if (done_hit) iter_rem <= iter_rem - 1'b1;
      end
   end
   assign core_start = state == S_START;
   assign done_irq   = state == S_DONE;
   // Built only from flops, so it always shows state as of the last edge.
   always_comb begin
      status                   = '0;
      status[ST_BUSY]          = !idle;
      status[ST_ERR]           = err;
      status[ST_OVF]           = ovf;
      status[ST_STATE +: 3]    = state;
      status[ST_WCNT +: WORD_W] = word_cnt;
      status[ITER_W-1:0]       = iter_rem;
   end
   ising_row_writer u_row (
      .clk      (aclk),
      .rst      (areset),
      .wr       (wr),
      .sel      (mem_sel_e'(reg_wr_idx[1:0])),
      .data     (reg_wr_data),
      .set_base (set_base),
      .clr      (clr_hit),
      .mem_we   (mem_we),
      .mem_sel  (mem_sel),
      .mem_addr (mem_addr),
      .mem_word (mem_word),
      .mem_wdata(mem_wdata),
      .word_cnt (word_cnt),
      .ovf      (ovf)
   );
endmodule

// File: tb/tb_ising_seq_ctrl.sv
// tb_ising_seq_ctrl: table-driven and scoreboard bench for the Ising command sequencer
module tb_ising_seq_ctrl;
   logic        aclk = 1'b0, areset = 1'b1, reg_wr_en = 1'b0, core_done = 1'b0;
   logic [3:0]  reg_wr_idx = '0;
   logic [31:0] reg_wr_data = '0;
   logic        mem_we, core_clear, core_start, done_irq;
   logic [1:0]  mem_sel;
   logic [10:0] mem_addr;
   logic [2:0]  mem_word;
   logic [31:0] mem_wdata, status;

   ising_seq_ctrl dut (
      .aclk(aclk), .areset(areset), .reg_wr_en(reg_wr_en), .reg_wr_idx(reg_wr_idx),
      .reg_wr_data(reg_wr_data), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
      .mem_word(mem_word), .mem_wdata(mem_wdata), .core_clear(core_clear),
      .core_start(core_start), .core_done(core_done), .done_irq(done_irq), .status(status)
   );

   always #5 aclk = ~aclk;

   typedef struct {
      logic [3:0]  idx;
      logic [31:0] data;
      bit          we;
      logic [2:0]  word;
      logic [10:0] addr;
      bit          ovf;
      logic [2:0]  wcnt;
      bit          clr;
   } vec_t;
   typedef struct {
      int          cyc;
      logic [1:0]  sel;
      logic [10:0] addr;
      logic [2:0]  word;
      logic [31:0] data;
   } exp_t;

   int checks = 0, errors = 0, cyc = 0;
   exp_t sb[$];
   vec_t tbl[$];
   logic [15:0] iq[$];
   int starts = 0, irqs = 0, we_cnt = 0, irq_cyc = 0, busy_clr_cyc = 0, dly = 0;
   logic irq_busy = 1'b0, prev_busy = 1'b0;
   logic [15:0] last_iter = '0;
   bit model_en = 1'b1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic wr(input logic [3:0] idx, input logic [31:0] data);
      reg_wr_en   = 1'b1;
      reg_wr_idx  = idx;
      reg_wr_data = data;
      tick();
      reg_wr_en   = 1'b0;
      reg_wr_idx  = '0;
      reg_wr_data = '0;
   endtask

   function automatic vec_t mk(input logic [3:0] idx, input logic [31:0] data, input bit we,
                               input logic [2:0] word, input logic [10:0] addr, input bit ovf,
                               input logic [2:0] wcnt, input bit clr);
      vec_t v;
      v.idx = idx; v.data = data; v.we = we; v.word = word;
      v.addr = addr; v.ovf = ovf; v.wcnt = wcnt; v.clr = clr;
      return v;
   endfunction

   always @(posedge aclk) cyc <= cyc + 1;

   // Core model: answers each start with a done pulse about ten cycles later.
   always @(negedge aclk) begin
      core_done = 1'b0;
      if (dly != 0) begin
         dly = dly - 1;
         if (dly == 0) core_done = 1'b1;
      end
      if (core_start && model_en) dly = 10;
   end

   always @(negedge aclk) begin
      exp_t e;
      if (!areset && mem_we) begin
         we_cnt++;
         if (sb.size() == 0) chk("unexpected_mem_we", mem_we, 1'b0);
         else begin
            e = sb.pop_front();
            chk("mem_cycle", cyc, e.cyc);
            chk("mem_sel", mem_sel, e.sel);
            chk("mem_addr", mem_addr, e.addr);
            chk("mem_word", mem_word, e.word);
            chk("mem_wdata", mem_wdata, e.data);
         end
      end
      if (core_start) starts++;
      if (done_irq) begin
         irqs++;
         irq_cyc  = cyc;
         irq_busy = status[31];
      end
      if (prev_busy && !status[31]) busy_clr_cyc = cyc;
      prev_busy = status[31];
      if (status[15:0] != last_iter) begin
         iq.push_back(status[15:0]);
         last_iter = status[15:0];
      end
   end

   initial begin
      int n0, i0, q0, w0;
      repeat (3) tick();
      chk("reset_status", status, 32'h0);
      chk("reset_strobes", {mem_we, core_clear, core_start, done_irq}, 4'h0);
      areset = 1'b0;
      tick();

      tbl.push_back(mk(4'd3, 32'h4, 0, 3'd0, 11'h0, 0, 3'd0, 0));
      for (int k = 1; k <= 8; k++)
         tbl.push_back(mk(4'd0, 32'(k % 2), 1, 3'(k - 1), 11'h4, k == 8, 3'(k % 8), 0));
      tbl.push_back(mk(4'd1, 32'hAB, 1, 3'd0, 11'h4, 1, 3'd1, 0));
      tbl.push_back(mk(4'd7, 32'h55, 0, 3'd0, 11'h0, 1, 3'd1, 0));
      tbl.push_back(mk(4'd3, 32'hFFFF_F7FF, 0, 3'd0, 11'h0, 1, 3'd0, 0));
      tbl.push_back(mk(4'd2, 32'hDEAD_BEEF, 1, 3'd0, 11'h7FF, 1, 3'd1, 0));
      tbl.push_back(mk(4'd0, 32'h1234, 1, 3'd1, 11'h7FF, 1, 3'd2, 0));
      tbl.push_back(mk(4'd15, 32'h0, 0, 3'd0, 11'h0, 0, 3'd0, 1));
      foreach (tbl[i]) begin
         if (tbl[i].we) sb.push_back('{cyc + 1, tbl[i].idx[1:0], tbl[i].addr, tbl[i].word, tbl[i].data});
         wr(tbl[i].idx, tbl[i].data);
         chk($sformatf("row%0d_status_hi", i), status[31:23], {2'b00, tbl[i].ovf, 3'b000, tbl[i].wcnt});
         chk($sformatf("row%0d_core_clear", i), core_clear, tbl[i].clr);
      end
      tick();
      chk("sb_drained", sb.size(), 0);

      n0 = starts; i0 = irqs; q0 = iq.size();
      wr(4'd5, 32'd3);
      for (int i = 0; i < 300 && !(irqs > i0 && !status[31]); i++) tick();
      repeat (15) tick();
      chk("run3_starts", starts - n0, 3);
      chk("run3_irqs", irqs - i0, 1);
      chk("run3_iter_changes", iq.size() - q0, 4);
      for (int k = 0; k < 4 && q0 + k < iq.size(); k++)
         chk($sformatf("run3_iter%0d", k), iq[q0 + k], 16'(3 - k));
      chk("run3_busy_at_irq", irq_busy, 1'b1);
      chk("run3_busy_clear_cycle", busy_clr_cyc, irq_cyc + 1);

      n0 = starts; i0 = irqs;
      wr(4'd5, 32'd0);
      for (int i = 0; i < 100 && !(irqs > i0 && !status[31]); i++) tick();
      repeat (15) tick();
      chk("run0_starts", starts - n0, 1);
      chk("run0_irqs", irqs - i0, 1);

      model_en = 1'b0;
      i0 = irqs; w0 = we_cnt;
      wr(4'd5, 32'd5);
      repeat (3) tick();
      chk("busy_state_wait", status[28:26], 3'd2);
      wr(4'd1, 32'h2);
      tick();
      chk("busy_no_mem_we", we_cnt - w0, 0);
      chk("busy_err_set", status[30], 1'b1);
      wr(4'd5, 32'd9);
      chk("busy_restart_ignored", status[15:0], 16'd5);
      chk("busy_still_wait", status[28:26], 3'd2);
      wr(4'd15, 32'h0);
      chk("abort_idle", {status[31], status[28:26]}, 4'h0);
      chk("abort_err_clear", status[30], 1'b0);
      chk("abort_core_clear", core_clear, 1'b1);
      repeat (15) tick();
      chk("abort_no_irq", irqs - i0, 0);
      model_en = 1'b1;

      wr(4'd5, 32'd2);
      for (int i = 0; i < 20 && status[28:26] != 3'd2; i++) tick();
      areset = 1'b1;
      tick();
      chk("midrun_reset_status", status, 32'h0);
      chk("midrun_reset_outs", {mem_we, mem_sel, mem_addr, mem_word, mem_wdata, core_clear, core_start, done_irq}, 52'h0);
      areset = 1'b0;
      n0 = starts; i0 = irqs;
      repeat (25) tick();
      chk("post_reset_no_start", starts - n0, 0);
      chk("post_reset_no_irq", irqs - i0, 0);
      chk("post_reset_status", status, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
